// File: rtl/bk_pkg.sv
// Shared types and helpers for the BK vectored interrupt controller.
// Holds the FSM state type, vector width and the fixed-priority encoder.
package bk_pkg;

    localparam int VEC_W  = 16;
    localparam int MAX_CH = 16;

    typedef enum logic {
        IDLE,
        ACK
    } vic_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    // Lowest set index wins; scanning downward lets it overwrite last.
    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] req);
        prio_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vic_chan.sv
// One interrupt request channel: edge-latched or level-following pending bit.
// Sampling runs every clk_sys regardless of the bus clock enable.
module vic_chan #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ireq,
    input  logic clr,
    output logic pending
);

    logic ireq_d;

    // A fresh edge in the same clock as service keeps the bit set.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ireq_d  <= 1'b0;
            pending <= 1'b0;
        end else begin
            ireq_d <= ireq;
            if (EDGE) begin
                pending <= (ireq & ~ireq_d) | (pending & ~clr);
            end else begin
                pending <= ireq;
            end
        end
    end

endmodule

// File: rtl/vic_nch.sv
// N-channel vectored interrupt controller with fixed lowest-index priority.
// Serves the CPU acknowledge cycle with a frozen vector, or DEF_VEC if idle.
module vic_nch
    import bk_pkg::*;
#(
    parameter int               NCH       = 4,
    parameter logic [NCH-1:0]   EDGE_MASK = {NCH{1'b1}},
    parameter logic [VEC_W-1:0] DEF_VEC   = 16'o000000
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce,
    input  logic [NCH-1:0]     ireq,
    input  logic [NCH-1:0]     imask,
    input  logic [VEC_W*NCH-1:0] ivec,
    output logic [NCH-1:0]     iack,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic [VEC_W-1:0]   wb_dat_o,
    output logic               wb_irq_o,
    output logic [NCH-1:0]     pending
);

    vic_state_t       state_q;
    vic_state_t       state_d;
    logic [NCH-1:0]   clr;
    logic [MAX_CH-1:0] req16;
    prio_t            sel;
    logic             svc;
    logic             rel;
    logic [VEC_W-1:0] sel_vec;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        vic_chan #(
            .EDGE (EDGE_MASK[k])
        ) u_chan (
            .clk_sys (clk_sys),
            .reset   (reset),
            .ireq    (ireq[k]),
            .clr     (clr[k]),
            .pending (pending[k])
        );
    end

    always_comb begin
        req16            = '0;
        req16[NCH-1:0]   = pending & ~imask;
        sel              = prio_enc(req16);
    end

    always_comb begin
        state_d = state_q;
        svc     = 1'b0;
        rel     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce && wb_stb_i) begin
                    svc     = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (ce && !wb_stb_i) begin
                    rel     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr     = '0;
        sel_vec = DEF_VEC;
        for (int k = 0; k < NCH; k++) begin
            if (svc && sel.valid && (sel.idx == 4'(k))) begin
                clr[k]  = 1'b1;
                sel_vec = ivec[k*VEC_W +: VEC_W];
            end
        end
    end

    // The request line is gated by the next state so it drops with ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            wb_irq_o <= 1'b0;
            iack     <= '0;
        end else begin
            state_q  <= state_d;
            iack     <= clr;
            wb_irq_o <= (state_d == IDLE) && (|(pending & ~imask));
            if (svc) begin
                wb_ack_o <= 1'b1;
                wb_dat_o <= sel_vec;
            end else if (rel) begin
                wb_ack_o <= 1'b0;
                wb_dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vic_nch.sv
// Randomised scoreboard bench for vic_nch: four channels, channel 0 level.
// Reference model tracks pending, irq and expected vectors per clock.
module tb_vic_nch;

    localparam int          NCH  = 4;
    localparam logic [3:0]  EDGE = 4'b1110;
    localparam logic [15:0] DEF  = 16'o000777;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce;
    logic [3:0]    ireq;
    logic [3:0]    imask;
    logic [63:0]   ivec;
    logic [3:0]    iack;
    logic          wb_stb_i;
    logic          wb_ack_o;
    logic [15:0]   wb_dat_o;
    logic          wb_irq_o;
    logic [3:0]    pending;

    always #5 clk_sys = ~clk_sys;

    vic_nch #(
        .NCH       (NCH),
        .EDGE_MASK (EDGE),
        .DEF_VEC   (DEF)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .ireq     (ireq),
        .imask    (imask),
        .ivec     (ivec),
        .iack     (iack),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o),
        .wb_irq_o (wb_irq_o),
        .pending  (pending)
    );

    typedef struct {
        logic [15:0] vec;
        logic [3:0]  iack;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [3:0]  m_pend, m_prev, m_iack;
    bit          m_ack, m_irq;
    bit          ack_seen;
    logic [15:0] hold_vec;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: acknowledge picks the lowest unmasked pending channel.
    always @(posedge clk_sys or posedge reset) begin
        logic [3:0] old;
        logic [3:0] served;
        int         hit;
        if (reset) begin
            m_pend = '0;
            m_prev = '0;
            m_iack = '0;
            m_ack  = 1'b0;
            m_irq  = 1'b0;
            sb.delete();
        end else begin
            old    = m_pend;
            served = '0;
            if (ce && !m_ack && wb_stb_i) begin
                hit = -1;
                for (int k = NCH - 1; k >= 0; k--)
                    if (old[k] && !imask[k]) hit = k;
                if (hit >= 0) begin
                    served = 4'(1 << hit);
                    sb.push_back('{ivec[hit*16 +: 16], served});
                end else begin
                    sb.push_back('{DEF, 4'b0000});
                end
                m_ack = 1'b1;
            end else if (ce && m_ack && !wb_stb_i) begin
                m_ack = 1'b0;
            end
            for (int k = 0; k < NCH; k++) begin
                if (EDGE[k])
                    m_pend[k] = (ireq[k] && !m_prev[k]) || (old[k] && !served[k]);
                else
                    m_pend[k] = ireq[k];
            end
            m_irq  = !m_ack && (|(old & ~imask));
            m_prev = ireq;
            m_iack = served;
        end
    end

    // Monitor: per-cycle status checks plus scoreboard pop on each new ack.
    always @(posedge clk_sys) begin
        exp_t e;
        #1;
        if (!reset) begin
            chk("pending", 32'(pending), 32'(m_pend));
            chk("irq", 32'(wb_irq_o), 32'(m_irq));
            chk("iack", 32'(iack), 32'(m_iack));
            chk("ack", 32'(wb_ack_o), 32'(m_ack));
            if (!wb_ack_o) chk("dat_idle", 32'(wb_dat_o), 32'd0);
            if (wb_ack_o && !ack_seen) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL sb_empty: ack with dat %h, nothing expected", wb_dat_o);
                end else begin
                    e = sb.pop_front();
                    hold_vec = e.vec;
                    chk("vec", 32'(wb_dat_o), 32'(e.vec));
                    chk("svc_iack", 32'(iack), 32'(e.iack));
                end
            end else if (wb_ack_o) begin
                chk("vec_hold", 32'(wb_dat_o), 32'(hold_vec));
            end
        end
        ack_seen = wb_ack_o;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b1;
        ireq     = '0;
        imask    = '0;
        wb_stb_i = 1'b0;
        ivec     = {16'o000374, 16'o000274, 16'o000174, 16'o000074};
        step(2);
        reset = 1'b0;
        #1;
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_irq", 32'(wb_irq_o), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
        chk("rst_iack", 32'(iack), 32'd0);

        // single edge on ch2
        step(1);
        ireq = 4'b0100; step(1);
        ireq = 4'b0000; step(3);
        wb_stb_i = 1'b1; step(2);
        wb_stb_i = 1'b0; step(2);

        // simultaneous ch1 and ch3
        ireq = 4'b1010; step(1);
        ireq = 4'b0000; step(2);
        wb_stb_i = 1'b1; step(1);
        wb_stb_i = 1'b0; step(1);
        wb_stb_i = 1'b1; step(1);
        wb_stb_i = 1'b0; step(2);

        // masked ch0 (level, held) with ch2 edge
        imask = 4'b0001;
        ireq  = 4'b0101; step(1);
        ireq  = 4'b0001; step(2);
        wb_stb_i = 1'b1; step(2);
        wb_stb_i = 1'b0; step(1);
        imask = 4'b0000; step(3);
        wb_stb_i = 1'b1; step(2);
        wb_stb_i = 1'b0; step(4);
        ireq = 4'b0000; step(3);

        // nothing pending: default vector
        wb_stb_i = 1'b1; step(3);
        wb_stb_i = 1'b0; step(2);

        // reset in the middle of an acknowledge
        ireq = 4'b0010; step(1);
        ireq = 4'b0000; step(2);
        wb_stb_i = 1'b1; step(1);
        reset = 1'b1;
        #1;
        chk("arst_ack", 32'(wb_ack_o), 32'd0);
        chk("arst_dat", 32'(wb_dat_o), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_irq", 32'(wb_irq_o), 32'd0);
        step(1);
        reset    = 1'b0;
        wb_stb_i = 1'b0;
        step(1);
        ireq = 4'b1000; step(1);
        ireq = 4'b0000; step(3);
        wb_stb_i = 1'b1; step(1);
        wb_stb_i = 1'b0; step(2);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            ireq = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 7) == 0) imask = 4'($urandom);
            if ($urandom_range(0, 7) == 0) ivec = {$urandom, $urandom};
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) wb_stb_i = ~wb_stb_i;
            step(1);
        end
        ce       = 1'b1;
        wb_stb_i = 1'b0;
        ireq     = '0;
        step(4);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
